shared_adder_scheduler: RTL

Sequencer and arbiter that shares one external 4-bit ripple-carry adder between two requesters. Each request is a WIDTH-bit add, which the block runs one nibble per cycle, least significant nibble first, chaining the carry through an internal register. The block sits in front of the combinational 4-bit adder and drives its A/B/Cin inputs. It returns each full-width result on a valid/ready result port tagged with the requester ID.

---
 rtl/shared_adder_scheduler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shared_adder_scheduler.sv
// Shares one external 4-bit adder between two requesters: arbitrates round-robin,
// runs a WIDTH-bit add one nibble per cycle (LSB first), returns the result tagged by id.
module shared_adder_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic [CW-1:0]    cnt;
  logic             carry, id_reg, last_grant;
  logic             grant0, grant1, accept;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && grant0 && !rst;
  assign req1_ready = (state == IDLE) && grant1 && !rst;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = RUN;
      RUN:     if (cnt == LAST)   state_nxt = DONE;
      DONE:    if (res_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Operand, carry-chain and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_reg      <= req1_ready ? req1_a   : req0_a;
          b_reg      <= req1_ready ? req1_b   : req0_b;
          carry      <= req1_ready ? req1_cin : req0_cin;
          id_reg     <= req1_ready;
          last_grant <= req1_ready;
          cnt        <= '0;
        end
        RUN: begin
          sum_reg[{cnt, 2'b00} +: 4] <= add_sum;
          carry                      <= add_cout;
          if (cnt != LAST) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    res_valid = 1'b0;
    res_sum   = '0;
    res_cout  = 1'b0;
    res_id    = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[{cnt, 2'b00} +: 4];
      add_b   = b_reg[{cnt, 2'b00} +: 4];
      add_cin = carry;
    end
    if (state == DONE) begin
      res_valid = 1'b1;
      res_sum   = sum_reg;
      res_cout  = carry;
      res_id    = id_reg;
    end
  end

endmodule
